control_unit: RTL and testbench
===============================

# control_unit

Hardwired sequencer that drives every control strobe of `datapath`. It fetches an instruction and decodes the 5-bit `opcode` from IR. It then steps through the execute micro-steps T3..T7, replacing the hand-written per-instruction stimulus FSMs with one synthesizable block. The block sits beside `datapath`: its outputs connect to the datapath control inputs, and it takes back `opcode` and the CON flip-flop output.

## Interface
- `OPW`, 5: opcode width.
- `ALU_ADD`, 5'b00011: alu_op value used for address, immediate and branch-target adds.
- `clk` in 1: single system clock; all state changes on rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `stop` in 1: request halt at the next instruction boundary.
- `opcode` in 5: IR[31:27] from datapath.
- `con_ff` in 1: registered branch-condition result from datapath.
- `PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout` out 1: bus drivers.
- `PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, OutPortIn, CONin` out 1: register loads.
- `IncPC, Read, RAMin, GRA, GRB, GRC` out 1: PC increment, memory read, memory write, and register-field selects.
- `alu_op` out 5: ALU function select.
- `run` out 1: high while executing; low in HALT.

## Operation
- States: `RST`, `T0`..`T7`, `HALT`, in a 4-bit register. Outputs decode combinationally from state, `opcode` and `con_ff`. Any strobe not listed for a step is 0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: ZLowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute steps, by opcode:
  - Reg ALU (add 00011, sub 00100, shr..rol 00101–01000, and 01001, or 01010): T3 GRB Rout Yin; T4 GRC Rout ZLowIn alu_op=opcode; T5 ZLowout GRA Rin.
  - Immediate ALU (addi 01011, andi 01100, ori 01101): T3 GRB Rout Yin; T4 Cout ZLowIn alu_op=opcode; T5 ZLowout GRA Rin.
  - ldi 00001: T3 GRB BAout Yin; T4 Cout ZLowIn alu_op=ALU_ADD; T5 ZLowout GRA Rin.
  - ld 00000: T3–T4 as ldi; T5 ZLowout MARin; T6 Read MDRin; T7 MDRout GRA Rin.
  - st 00010: T3–T5 as ld; T6 GRA Rout MDRin; T7 RAMin.
  - mul 01110, div 01111: T3 GRA Rout Yin; T4 GRB Rout ZLowIn ZHighIn alu_op=opcode; T5 ZLowout LOin; T6 ZHighout HIin.
  - br 10010: T3 GRA Rout CONin; T4 PCout Yin; T5 Cout ZLowIn alu_op=ALU_ADD; T6 ZLowout and PCin=con_ff.
  - jr 10011: T3 GRA Rout PCin.
  - in 10101: T3 InPortOut GRA Rin.
  - out 10110: T3 GRA Rout OutPortIn.
  - mfhi 10111: T3 HIout GRA Rin.
  - mflo 11000: T3 LOout GRA Rin.
  - nop 11001, and all undefined opcodes: no execute step.
  - halt 11010: enter HALT after T2.
- Transitions:
  - RST→T0.
  - T0→T1→T2.
  - T2→T3 when the instruction has execute steps; otherwise →T0, or →HALT for halt.
  - From the instruction's last step: →HALT if `stop`=1, else →T0.
  - HALT is held until `clr`.

## Timing
- Async `clr`: state=RST immediately. All outputs 0, `alu_op`=0, `run`=1. The first rising edge after release moves the state to T0.
- `clr` mid-instruction aborts the instruction; there is no partial write after the reset edge.
- Each step lasts exactly one clock. Instruction lengths include fetch:
  - 3 cycles: nop.
  - 4 cycles: jr, in, out, mfhi, mflo.
  - 6 cycles: ALU ops, ldi.
  - 7 cycles: mul, div, br.
  - 8 cycles: ld, st.
- `stop` is sampled only on the final step's edge. `stop` asserted during fetch takes effect at the end of that instruction.
- `con_ff` is sampled combinationally in T6. The datapath latches CON at the end of T3.
- `run` falls in the first HALT cycle.

## Structure
- Shared package `cpu_defs`: opcode constants, state encodings, `ALU_ADD`. The datapath ALU also uses these.
- One combinational sub-module, `instr_class_decode`: opcode→class (REG_ALU, IMM_ALU, LDI, LD, ST, MULDIV, BR, JR, IN, OUT, MFHI, MFLO, NOP, HALT) plus last-step index.

## Test plan
- add (IR=0x18A98000, opcode 00011) → T0..T5. Exactly one step with GRC Rout ZLowIn alu_op=00011. GRA Rin in T5. T0 on the 7th edge.
- ld (opcode 00000) → Read=1 in T1 and T6. MARin in T0 and T5. GRA Rin in T7. 8 cycles total.
- br with con_ff=1 → PCin=1 in T6. br with con_ff=0 → PCin=0 throughout T3–T6. Both return to T0.
- st with `stop`=1 raised in T4 → RAMin pulses in T7, then HALT, `run`=0, no further PCout.
- `clr` pulsed in T5 of mul → all outputs 0 asynchronously, LOin/HIin never asserted. The next cycle is T0.
- halt opcode 11010 → HALT after T2. State unchanged for 20 cycles despite opcode changes.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: definitions shared by the control unit and the datapath.
//   - opcode constants (IR[31:27])
//   - ALU_ADD, the alu_op used for address, immediate and branch-target adds
//   - sequencer state encodings (4-bit)
//   - instruction class enumeration produced by instr_class_decode
package cpu_defs;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] ALU_ADD = 5'b00011;

  // Opcodes
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_AND  = 5'b01001;
  localparam logic [OPW-1:0] OP_OR   = 5'b01010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_IN   = 5'b10101;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  // Sequencer states. T0..T7 are consecutive so "next step" is a +1.
  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_T7   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

  typedef enum logic [3:0] {
    CL_REG_ALU = 4'd0,
    CL_IMM_ALU = 4'd1,
    CL_LDI     = 4'd2,
    CL_LD      = 4'd3,
    CL_ST      = 4'd4,
    CL_MULDIV  = 4'd5,
    CL_BR      = 4'd6,
    CL_JR      = 4'd7,
    CL_IN      = 4'd8,
    CL_OUT     = 4'd9,
    CL_MFHI    = 4'd10,
    CL_MFLO    = 4'd11,
    CL_NOP     = 4'd12,
    CL_HALT    = 4'd13
  } instr_class_e;

endpackage

// File: rtl/control_unit_instr_class_decode.sv
// instr_class_decode: purely combinational opcode classifier.
// Ports:
//   opcode     in  5 : IR[31:27]
//   iclass     out 4 : instruction class (cpu_defs::instr_class_e encoding)
//   last_state out 4 : state holding the instruction's final step
//                      (ST_T2 for instructions without execute steps)
module instr_class_decode
  import cpu_defs::*;
(
  input  logic [OPW-1:0] opcode,
  output logic [3:0]     iclass,
  output logic [3:0]     last_state
);

  // Map each opcode to its class and final micro-step; unknown opcodes act as nop.
  always_comb begin
    iclass     = CL_NOP;
    last_state = ST_T2;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
        iclass     = CL_REG_ALU;
        last_state = ST_T5;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        iclass     = CL_IMM_ALU;
        last_state = ST_T5;
      end
      OP_LDI: begin
        iclass     = CL_LDI;
        last_state = ST_T5;
      end
      OP_LD: begin
        iclass     = CL_LD;
        last_state = ST_T7;
      end
      OP_ST: begin
        iclass     = CL_ST;
        last_state = ST_T7;
      end
      OP_MUL, OP_DIV: begin
        iclass     = CL_MULDIV;
        last_state = ST_T6;
      end
      OP_BR: begin
        iclass     = CL_BR;
        last_state = ST_T6;
      end
      OP_JR: begin
        iclass     = CL_JR;
        last_state = ST_T3;
      end
      OP_IN: begin
        iclass     = CL_IN;
        last_state = ST_T3;
      end
      OP_OUT: begin
        iclass     = CL_OUT;
        last_state = ST_T3;
      end
      OP_MFHI: begin
        iclass     = CL_MFHI;
        last_state = ST_T3;
      end
      OP_MFLO: begin
        iclass     = CL_MFLO;
        last_state = ST_T3;
      end
      OP_HALT: begin
        iclass     = CL_HALT;
        last_state = ST_T2;
      end
      default: begin
        iclass     = CL_NOP;
        last_state = ST_T2;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for datapath.
// Ports:
//   clk, clr (async, active-high), stop (halt at next instruction boundary)
//   opcode (IR[31:27]), con_ff (registered branch condition)
//   bus drivers : PCout ZLowout ZHighout MDRout HIout LOout Cout InPortOut BAout Rout
//   loads       : PCin IRin MARin MDRin Yin ZLowIn ZHighIn HIin LOin Rin OutPortIn CONin
//   misc        : IncPC Read RAMin GRA GRB GRC, alu_op[4:0], run
// Outputs decode combinationally from the state register, opcode and con_ff.
module control_unit
  import cpu_defs::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           stop,
  input  logic [OPW-1:0] opcode,
  input  logic           con_ff,
  output logic           PCout,
  output logic           ZLowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           Cout,
  output logic           InPortOut,
  output logic           BAout,
  output logic           Rout,
  output logic           PCin,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           Yin,
  output logic           ZLowIn,
  output logic           ZHighIn,
  output logic           HIin,
  output logic           LOin,
  output logic           Rin,
  output logic           OutPortIn,
  output logic           CONin,
  output logic           IncPC,
  output logic           Read,
  output logic           RAMin,
  output logic           GRA,
  output logic           GRB,
  output logic           GRC,
  output logic [OPW-1:0] alu_op,
  output logic           run
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] iclass;
  logic [3:0] last_state;

  instr_class_decode u_decode (
    .opcode     (opcode),
    .iclass     (iclass),
    .last_state (last_state)
  );

  // Next-state: fetch is fixed, execute runs up to the class's last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if ((state_q == ST_T2) && (iclass == CL_HALT)) begin
          state_d = ST_HALT;
        end else if (state_q >= last_state) begin
          // ">=" keeps the sequencer bounded even if opcode moves mid-execute
          state_d = stop ? ST_HALT : ST_T0;
        end else begin
          state_d = state_q + 4'd1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // State register; clr forces RST immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Control strobe decode per step and instruction class.
  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; Cout = 1'b0; InPortOut = 1'b0; BAout = 1'b0; Rout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0; Rin = 1'b0;
    OutPortIn = 1'b0; CONin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; RAMin = 1'b0; GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;
    alu_op = 5'b00000;
    run    = (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
      end
      ST_T1: begin
        ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        case (iclass)
          CL_REG_ALU, CL_IMM_ALU: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_LDI, CL_LD, CL_ST:   begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_MULDIV: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_BR:     begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CL_JR:     begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CL_IN:     begin InPortOut = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_OUT:    begin GRA = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          CL_MFHI:   begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_MFLO:   begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default:   begin end
        endcase
      end
      ST_T4: begin
        case (iclass)
          CL_REG_ALU: begin GRC = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
          CL_IMM_ALU: begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
          CL_LDI, CL_LD, CL_ST: begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = ALU_ADD; end
          CL_MULDIV: begin
            GRB = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; alu_op = opcode;
          end
          CL_BR:     begin PCout = 1'b1; Yin = 1'b1; end
          default:   begin end
        endcase
      end
      ST_T5: begin
        case (iclass)
          CL_REG_ALU, CL_IMM_ALU, CL_LDI: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
          CL_MULDIV:    begin ZLowout = 1'b1; LOin = 1'b1; end
          CL_BR:        begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = ALU_ADD; end
          default:      begin end
        endcase
      end
      ST_T6: begin
        case (iclass)
          CL_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          CL_ST:     begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CL_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          // branch target is only taken when the latched condition holds
          CL_BR:     begin ZLowout = 1'b1; PCin = con_ff; end
          default:   begin end
        endcase
      end
      ST_T7: begin
        case (iclass)
          CL_LD:   begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_ST:   begin RAMin = 1'b1; end
          default: begin end
        endcase
      end
      default: begin end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. A per-opcode micro-program table
// (lists of expected strobe words) is built from the instruction rules and
// replayed against the DUT cycle by cycle, with directed cases followed by
// random opcodes, stop and con_ff.
module tb_control_unit;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic clr, stop, con_ff;
  logic [4:0] opcode;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout;
  logic PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, OutPortIn, CONin;
  logic IncPC, Read, RAMin, GRA, GRB, GRC, run;
  logic [4:0] alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  control_unit dut (
    .clk(clk), .clr(clr), .stop(stop), .opcode(opcode), .con_ff(con_ff),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortOut(InPortOut),
    .BAout(BAout), .Rout(Rout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin),
    .LOin(LOin), .Rin(Rin), .OutPortIn(OutPortIn), .CONin(CONin),
    .IncPC(IncPC), .Read(Read), .RAMin(RAMin), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .alu_op(alu_op), .run(run)
  );

  always #5 clk = ~clk;

  localparam logic [27:0] M_PCOUT     = 28'd1 << 0;
  localparam logic [27:0] M_ZLOWOUT   = 28'd1 << 1;
  localparam logic [27:0] M_ZHIGHOUT  = 28'd1 << 2;
  localparam logic [27:0] M_MDROUT    = 28'd1 << 3;
  localparam logic [27:0] M_HIOUT     = 28'd1 << 4;
  localparam logic [27:0] M_LOOUT     = 28'd1 << 5;
  localparam logic [27:0] M_COUT      = 28'd1 << 6;
  localparam logic [27:0] M_INPORTOUT = 28'd1 << 7;
  localparam logic [27:0] M_BAOUT     = 28'd1 << 8;
  localparam logic [27:0] M_ROUT      = 28'd1 << 9;
  localparam logic [27:0] M_PCIN      = 28'd1 << 10;
  localparam logic [27:0] M_IRIN      = 28'd1 << 11;
  localparam logic [27:0] M_MARIN     = 28'd1 << 12;
  localparam logic [27:0] M_MDRIN     = 28'd1 << 13;
  localparam logic [27:0] M_YIN       = 28'd1 << 14;
  localparam logic [27:0] M_ZLOWIN    = 28'd1 << 15;
  localparam logic [27:0] M_ZHIGHIN   = 28'd1 << 16;
  localparam logic [27:0] M_HIIN      = 28'd1 << 17;
  localparam logic [27:0] M_LOIN      = 28'd1 << 18;
  localparam logic [27:0] M_RIN       = 28'd1 << 19;
  localparam logic [27:0] M_OUTPORTIN = 28'd1 << 20;
  localparam logic [27:0] M_CONIN     = 28'd1 << 21;
  localparam logic [27:0] M_INCPC     = 28'd1 << 22;
  localparam logic [27:0] M_READ      = 28'd1 << 23;
  localparam logic [27:0] M_RAMIN     = 28'd1 << 24;
  localparam logic [27:0] M_GRA       = 28'd1 << 25;
  localparam logic [27:0] M_GRB       = 28'd1 << 26;
  localparam logic [27:0] M_GRC       = 28'd1 << 27;

  logic [27:0] obs;
  assign obs = {GRC, GRB, GRA, RAMin, Read, IncPC,
                CONin, OutPortIn, Rin, LOin, HIin, ZHighIn, ZLowIn, Yin, MDRin, MARin, IRin, PCin,
                Rout, BAout, InPortOut, Cout, LOout, HIout, MDRout, ZHighout, ZLowout, PCout};

  typedef struct {
    logic [27:0] s;
    logic [4:0]  a;
    logic        pc_con;  // PCin follows con_ff in this step
  } uword_t;

  uword_t prog[$];

  function automatic void push(input logic [27:0] s, input logic [4:0] a, input logic c);
    uword_t w;
    w.s = s; w.a = a; w.pc_con = c;
    prog.push_back(w);
  endfunction

  // Micro-program for one instruction: fetch words followed by execute words.
  function automatic void build(input logic [4:0] op);
    logic [27:0] addr_t3;
    prog.delete();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'd0, 1'b0);
    push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b0);
    push(M_MDROUT | M_IRIN, 5'd0, 1'b0);
    addr_t3 = M_GRB | M_BAOUT | M_YIN;
    if (op >= 5'd3 && op <= 5'd10) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
      push(M_GRC | M_ROUT | M_ZLOWIN, op, 1'b0);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op >= 5'd11 && op <= 5'd13) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
      push(M_COUT | M_ZLOWIN, op, 1'b0);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op == 5'd1) begin
      push(addr_t3, 5'd0, 1'b0);
      push(M_COUT | M_ZLOWIN, 5'd3, 1'b0);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op == 5'd0 || op == 5'd2) begin
      push(addr_t3, 5'd0, 1'b0);
      push(M_COUT | M_ZLOWIN, 5'd3, 1'b0);
      push(M_ZLOWOUT | M_MARIN, 5'd0, 1'b0);
      if (op == 5'd0) begin
        push(M_READ | M_MDRIN, 5'd0, 1'b0);
        push(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0);
      end else begin
        push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0);
        push(M_RAMIN, 5'd0, 1'b0);
      end
    end else if (op == 5'd14 || op == 5'd15) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0, 1'b0);
      push(M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN, op, 1'b0);
      push(M_ZLOWOUT | M_LOIN, 5'd0, 1'b0);
      push(M_ZHIGHOUT | M_HIIN, 5'd0, 1'b0);
    end else if (op == 5'd18) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0, 1'b0);
      push(M_PCOUT | M_YIN, 5'd0, 1'b0);
      push(M_COUT | M_ZLOWIN, 5'd3, 1'b0);
      push(M_ZLOWOUT, 5'd0, 1'b1);
    end else if (op == 5'd19) push(M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b0);
    else if (op == 5'd21) push(M_INPORTOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    else if (op == 5'd22) push(M_GRA | M_ROUT | M_OUTPORTIN, 5'd0, 1'b0);
    else if (op == 5'd23) push(M_HIOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    else if (op == 5'd24) push(M_LOOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    else begin
      // nop, halt and undefined opcodes: fetch only
    end
  endfunction

  task automatic check(input string tag, input logic [27:0] es, input logic [4:0] ea,
                       input logic er);
    logic [33:0] got;
    logic [33:0] exp;
    got = {obs, alu_op, run};
    exp = {es, ea, er};
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed strobes=%h alu_op=%b run=%b, expected strobes=%h alu_op=%b run=%b",
             tag, got[33:6], got[5:1], got[0], exp[33:6], exp[5:1], exp[0]);
    end
  endtask

  // Replay one instruction. stop_from<0: random stop; else stop=1 from step stop_from.
  // con_val<0: random con_ff. halted reports whether the model expects HALT next.
  task automatic run_instr(input logic [4:0] op, input int stop_from, input int con_val,
                           output logic halted);
    logic        last_stop;
    logic [27:0] es;
    last_stop = 1'b0;
    build(op);
    for (int i = 0; i < prog.size(); i++) begin
      @(posedge clk); #1;
      opcode = op;
      stop   = (stop_from < 0) ? ($urandom_range(0, 7) == 0) : (i >= stop_from);
      con_ff = (con_val < 0) ? 1'($urandom_range(0, 1)) : con_val[0];
      @(negedge clk);
      es = prog[i].s;
      if (prog[i].pc_con && con_ff) es = es | M_PCIN;
      check($sformatf("op%b_T%0d", op, i), es, prog[i].a, 1'b1);
      last_stop = stop;
    end
    halted = (op == OP_HALT) || last_stop;
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      opcode = 5'($urandom_range(0, 31));
      stop   = 1'($urandom_range(0, 1));
      con_ff = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("halt_hold%0d", i), 28'd0, 5'd0, 1'b0);
    end
  endtask

  // Called just after a falling edge: pulse clr, check reset outputs, release.
  task automatic do_clr(input string tag);
    clr = 1'b1;
    #1;
    check(tag, 28'd0, 5'd0, 1'b1);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    logic h;
    logic [4:0] op;
    clr = 1'b1; stop = 1'b0; con_ff = 1'b0; opcode = 5'd0;
    #2;
    check("reset", 28'd0, 5'd0, 1'b1);
    @(negedge clk);
    clr = 1'b0;

    run_instr(OP_ADD, 100, 0, h);     // 6 steps, then T0 of the following nop
    run_instr(OP_NOP, 100, 0, h);
    run_instr(OP_LD, 100, 0, h);
    run_instr(OP_BR, 100, 1, h);
    run_instr(OP_BR, 100, 0, h);
    run_instr(OP_MUL, 100, 0, h);
    run_instr(OP_JR, 100, 0, h);
    run_instr(OP_ST, 4, 0, h);        // stop raised in T4 -> HALT after T7
    halt_hold(4);
    do_clr("clr_after_st");

    // clr during T5 of mul aborts before LOin/HIin
    build(OP_MUL);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      opcode = OP_MUL; stop = 1'b0; con_ff = 1'b0;
      if (i < 5) begin
        @(negedge clk);
        check($sformatf("mulabort_T%0d", i), prog[i].s, prog[i].a, 1'b1);
      end else begin
        clr = 1'b1;
        #1;
        check("clr_mul_T5", 28'd0, 5'd0, 1'b1);
        @(negedge clk);
        clr = 1'b0;
      end
    end
    run_instr(OP_NOP, 100, 0, h);

    run_instr(OP_HALT, 100, 0, h);
    halt_hold(20);
    do_clr("clr_after_halt");

    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == OP_HALT && $urandom_range(0, 3) != 0) op = OP_NOP;
      run_instr(op, -1, -1, h);
      if (h) begin
        halt_hold(3);
        do_clr("clr_random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
